core_hazard_sb: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order core pipeline.
- Replaces the fixed 4-register hazard control with a shadow scoreboard that tracks destination registers of all in-flight instructions across NSTG post-decode stages.
- Drives per-register enable/kill buses, operand forwarding selects and fetch redirect.
- Sits beside the pipeline top; consumes decode operand info, branch result and cache stalls.

---
 rtl/core_hazard_sb.sv | 135 +++++++++++++
 tb/tb_core_hazard_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_hazard_sb.sv
// Shadow-scoreboard hazard and forwarding controller for the in-order core pipeline.
// Optional performance counters are enabled with the CORE_HAZ_PERF_EN macro.
module core_hazard_sb #(
   parameter int NSTG       = 3,
   parameter int RA_W       = 5,
   parameter int LD_FWD_STG = 2,
   parameter int SEL_W      = $clog2(NSTG+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dec_val,
   input  logic [RA_W-1:0]   dec_rs1,
   input  logic [RA_W-1:0]   dec_rs2,
   input  logic              dec_rs1_use,
   input  logic              dec_rs2_use,
   input  logic [RA_W-1:0]   dec_rd,
   input  logic              dec_we,
   input  logic              dec_ld,
   input  logic              exe_brnch_tkn,
   input  logic              stall_i,
   input  logic              stall_d,
   output logic [NSTG:0]     haz_enb_bus,
   output logic [NSTG:0]     haz_kill_bus,
   output logic [SEL_W-1:0]  fwd_rs1_sel,
   output logic [SEL_W-1:0]  fwd_rs2_sel,
   output logic              haz_redirect
`ifdef CORE_HAZ_PERF_EN
   ,
   output logic [31:0]       perf_ld_stall,
   output logic [31:0]       perf_flush,
   output logic [31:0]       perf_dstall
`endif
);

   logic [NSTG-1:0] sb_vld;
   logic [NSTG-1:0] sb_we;
   logic [NSTG-1:0] sb_ld;
   logic [RA_W-1:0] sb_rd [NSTG];

   logic lu_rs1;
   logic lu_rs2;
   logic ld_use;
   logic ld_use_act;
   logic flush_act;

   // Scan oldest to youngest so the youngest matching entry is the last assignment.
   always_comb begin
      fwd_rs1_sel = '0;
      fwd_rs2_sel = '0;
      lu_rs1      = 1'b0;
      lu_rs2      = 1'b0;
      for (int j = NSTG-1; j >= 0; j--) begin
         if (sb_vld[j] && sb_we[j] && (sb_rd[j] == dec_rs1) && (dec_rs1 != '0) &&
             dec_rs1_use && dec_val) begin
            fwd_rs1_sel = SEL_W'(j+1);
            lu_rs1      = sb_ld[j] && (j < LD_FWD_STG);
         end
         if (sb_vld[j] && sb_we[j] && (sb_rd[j] == dec_rs2) && (dec_rs2 != '0) &&
             dec_rs2_use && dec_val) begin
            fwd_rs2_sel = SEL_W'(j+1);
            lu_rs2      = sb_ld[j] && (j < LD_FWD_STG);
         end
      end
   end

   assign ld_use = lu_rs1 | lu_rs2;

   // A memory stall freezes everything; a taken branch overrides any load-use hold.
   always_comb begin
      haz_enb_bus  = '1;
      haz_kill_bus = '0;
      haz_redirect = 1'b0;
      ld_use_act   = 1'b0;
      flush_act    = 1'b0;
      if (stall_d) begin
         haz_enb_bus = '0;
      end else if (exe_brnch_tkn) begin
         haz_kill_bus[1:0] = 2'b11;
         haz_redirect      = 1'b1;
         flush_act         = 1'b1;
      end else if (ld_use) begin
         haz_enb_bus[0]  = 1'b0;
         haz_kill_bus[1] = 1'b1;
         ld_use_act      = 1'b1;
      end else if (stall_i) begin
         haz_kill_bus[1] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_vld <= '0;
         sb_we  <= '0;
         sb_ld  <= '0;
      end else if (!stall_d) begin
         for (int j = NSTG-1; j >= 1; j--) begin
            sb_vld[j] <= sb_vld[j-1];
            sb_we[j]  <= sb_we[j-1];
            sb_ld[j]  <= sb_ld[j-1];
         end
         sb_vld[0] <= dec_val & ~haz_kill_bus[1];
         sb_we[0]  <= dec_we;
         sb_ld[0]  <= dec_ld;
      end
   end

   // Destination addresses are qualified by sb_vld, so they carry no reset.
   always_ff @(posedge clk) begin
      if (!stall_d) begin
         for (int j = NSTG-1; j >= 1; j--) begin
            sb_rd[j] <= sb_rd[j-1];
         end
         sb_rd[0] <= dec_rd;
      end
   end

`ifdef CORE_HAZ_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_ld_stall <= '0;
         perf_flush    <= '0;
         perf_dstall   <= '0;
      end else begin
         if (ld_use_act) perf_ld_stall <= sat_inc(perf_ld_stall);
         if (flush_act)  perf_flush    <= sat_inc(perf_flush);
         if (stall_d)    perf_dstall   <= sat_inc(perf_dstall);
      end
   end
`endif

endmodule

// File: tb/tb_core_hazard_sb.sv
// Bench for core_hazard_sb: directed scenarios plus randomized traffic against a queue-based model.
module tb_core_hazard_sb;
   localparam int NSTG  = 3;
   localparam int RA_W  = 5;
   localparam int LDF   = 2;
   localparam int SEL_W = $clog2(NSTG+1);

   logic clk = 1'b0;
   logic rst_n;
   logic dec_val, dec_rs1_use, dec_rs2_use, dec_we, dec_ld;
   logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
   logic exe_brnch_tkn, stall_i, stall_d;
   logic [NSTG:0] haz_enb_bus, haz_kill_bus;
   logic [SEL_W-1:0] fwd_rs1_sel, fwd_rs2_sel;
   logic haz_redirect;
`ifdef CORE_HAZ_PERF_EN
   logic [31:0] perf_ld_stall, perf_flush, perf_dstall;
   logic [31:0] base_dstall, base_flush;
`endif

   always #5 clk = ~clk;

   core_hazard_sb #(.NSTG(NSTG), .RA_W(RA_W), .LD_FWD_STG(LDF)) dut (
      .clk(clk), .rst_n(rst_n),
      .dec_val(dec_val), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use),
      .dec_rd(dec_rd), .dec_we(dec_we), .dec_ld(dec_ld),
      .exe_brnch_tkn(exe_brnch_tkn), .stall_i(stall_i), .stall_d(stall_d),
      .haz_enb_bus(haz_enb_bus), .haz_kill_bus(haz_kill_bus),
      .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
      .haz_redirect(haz_redirect)
`ifdef CORE_HAZ_PERF_EN
      , .perf_ld_stall(perf_ld_stall), .perf_flush(perf_flush), .perf_dstall(perf_dstall)
`endif
   );

   // In-flight instructions, youngest first (index 0 = EXE).
   typedef struct packed {
      logic            vld;
      logic [RA_W-1:0] rd;
      logic            we;
      logic            ld;
   } ent_t;
   ent_t inflight[$];

   int passed = 0;
   int total  = 0;
   logic exp_kill1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      inflight.delete();
      for (int i = 0; i < NSTG; i++) inflight.push_back('0);
   endtask

   // Returns forward select (age+1 of youngest producer) and whether it is a load too young to forward.
   task automatic lookup(input logic [RA_W-1:0] rs, input logic use_en,
                         output int sel, output logic lu);
      sel = 0;
      lu  = 1'b0;
      if (dec_val && use_en && rs != 0) begin
         for (int j = 0; j < NSTG; j++) begin
            if (inflight[j].vld && inflight[j].we && inflight[j].rd == rs) begin
               sel = j + 1;
               lu  = inflight[j].ld && (j < LDF);
               break;
            end
         end
      end
   endtask

   task automatic cmp_model();
      int s1, s2;
      logic l1, l2;
      logic [NSTG:0] e_enb, e_kill;
      logic e_red;
      lookup(dec_rs1, dec_rs1_use, s1, l1);
      lookup(dec_rs2, dec_rs2_use, s2, l2);
      e_enb  = {(NSTG+1){1'b1}};
      e_kill = '0;
      e_red  = 1'b0;
      if (stall_d) e_enb = '0;
      else if (exe_brnch_tkn) begin e_kill[0] = 1'b1; e_kill[1] = 1'b1; e_red = 1'b1; end
      else if (l1 || l2) begin e_enb[0] = 1'b0; e_kill[1] = 1'b1; end
      else if (stall_i) e_kill[1] = 1'b1;
      exp_kill1 = e_kill[1];
      chk("enb", 32'(haz_enb_bus), 32'(e_enb));
      chk("kill", 32'(haz_kill_bus), 32'(e_kill));
      chk("redirect", 32'(haz_redirect), 32'(e_red));
      chk("fwd_rs1", 32'(fwd_rs1_sel), 32'(s1));
      chk("fwd_rs2", 32'(fwd_rs2_sel), 32'(s2));
   endtask

   task automatic step(input logic v, input logic [RA_W-1:0] r1, input logic u1,
                       input logic [RA_W-1:0] r2, input logic u2,
                       input logic [RA_W-1:0] rd, input logic we, input logic ld,
                       input logic br, input logic si, input logic sd);
      dec_val = v; dec_rs1 = r1; dec_rs1_use = u1; dec_rs2 = r2; dec_rs2_use = u2;
      dec_rd = rd; dec_we = we; dec_ld = ld;
      exe_brnch_tkn = br; stall_i = si; stall_d = sd;
      #4;
      cmp_model();
   endtask

   task automatic tick();
      ent_t e;
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (!stall_d) begin
         e.vld = dec_val & ~exp_kill1;
         e.rd  = dec_rd;
         e.we  = dec_we;
         e.ld  = dec_ld;
         void'(inflight.pop_back());
         inflight.push_front(e);
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      // Empty scoreboard after reset.
      step(1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 0);
      chk("rst_enb", 32'(haz_enb_bus), 32'hF);
      chk("rst_kill", 32'(haz_kill_bus), 32'h0);
      tick();
      rst_n = 1'b1;

      // ADD x3 then immediate use.
      step(1, 1, 0, 2, 0, 3, 1, 0, 0, 0, 0); tick();
      step(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);
      chk("add_fwd1", 32'(fwd_rs1_sel), 32'd1);
      tick();
      // ADD x8, bubble, use.
      step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); tick();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0);
      chk("add_fwd2", 32'(fwd_rs1_sel), 32'd2);
      tick();

      // LW x7 then use: two bubbles then forward from entry 2.
      step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); tick();
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 7, 1, 11, 1, 0, 0, 0, 0);
         chk("lu_enb0", 32'(haz_enb_bus[0]), 32'd0);
         chk("lu_kill1", 32'(haz_kill_bus[1]), 32'd1);
         tick();
      end
      step(1, 0, 0, 7, 1, 11, 1, 0, 0, 0, 0);
      chk("lu_fwd3", 32'(fwd_rs2_sel), 32'd3);
      chk("lu_go", 32'(haz_enb_bus), 32'hF);
      tick();

      // Write to x0 never forwards.
      step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
      step(1, 0, 1, 0, 1, 12, 1, 0, 0, 0, 0);
      chk("x0_fwd", 32'(fwd_rs1_sel), 32'd0);
      chk("x0_enb", 32'(haz_enb_bus), 32'hF);
      tick();

      // Taken branch overrides load-use; killed decode must not enter entry 0.
      step(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0); tick();
      step(1, 10, 1, 0, 0, 10, 1, 0, 1, 0, 0);
      chk("br_kill", 32'(haz_kill_bus[1:0]), 32'd3);
      chk("br_red", 32'(haz_redirect), 32'd1);
      chk("br_enb", 32'(haz_enb_bus), 32'hF);
      tick();
      step(1, 10, 1, 0, 0, 13, 1, 0, 0, 0, 0);
      chk("br_e0_inv", 32'(fwd_rs1_sel), 32'd2);
      tick();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      // stall_d with a pending branch: frozen for 5 cycles, flush on the 6th.
`ifdef CORE_HAZ_PERF_EN
      base_dstall = perf_dstall;
      base_flush  = perf_flush;
`endif
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 1);
         chk("sd_enb", 32'(haz_enb_bus), 32'h0);
         chk("sd_red", 32'(haz_redirect), 32'd0);
         tick();
      end
      step(1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0);
      chk("sd_flush", 32'(haz_redirect), 32'd1);
      tick();
`ifdef CORE_HAZ_PERF_EN
      chk("perf_dstall", perf_dstall - base_dstall, 32'd5);
      chk("perf_flush", perf_flush - base_flush, 32'd1);
`endif

      // Mid-operation reset clears the scoreboard immediately.
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); tick();
      step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
      chk("pre_rst_fwd", 32'(fwd_rs1_sel), 32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      cmp_model();
      chk("mid_rst_fwd", 32'(fwd_rs1_sel), 32'd0);
      tick();
      rst_n = 1'b1;

      // Randomized traffic on a small register range to provoke frequent hazards.
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 9) != 0),
              5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
              5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0),
              1'($urandom_range(0, 6) == 0));
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
